rifl_tx_lane_dist: RTL and testbench
====================================

// Module: rifl_tx_lane_dist
// PURPOSE
//  Distributes one wide user AXI4-Stream beat (N_CHANNEL x FRAME_WIDTH) across N_CHANNEL per-lane
//  TX frame streams, one slice per rifl_tx lane. Each lane has its own FIFO, so lanes drain
//  independently and a stalled lane never duplicates or drops a beat on the others.
//  Sits between the user s_axis port and the per-lane rifl_tx s_axis inputs, in the tx_frame_clk domain.
// PARAMETERS
//  N_CHANNEL    1    number of GT lanes
//  FRAME_WIDTH  256  data bits per lane per beat
//  FIFO_DEPTH   8    entries per lane FIFO; power of 2, >= 2
//  SKEW_LIMIT   6    lane_skew value at or above which skew_alarm sets; 1..FIFO_DEPTH
// PORTS
//  tx_frame_clk   in   1                      sole clock
//  rst            in   1                      synchronous, active-high
//  s_axis_tdata   in   N_CHANNEL*FRAME_WIDTH  lane i = bits [(i+1)*FRAME_WIDTH-1 -: FRAME_WIDTH]
//  s_axis_tkeep   in   N_CHANNEL*FRAME_WIDTH/8  per-lane keep, same slicing
//  s_axis_tlast   in   1                      copied to every lane
//  s_axis_tvalid  in   1
//  s_axis_tready  out  1
//  m_axis_tdata   out  N_CHANNEL*FRAME_WIDTH  per-lane head data
//  m_axis_tkeep   out  N_CHANNEL*FRAME_WIDTH/8
//  m_axis_tlast   out  N_CHANNEL
//  m_axis_tvalid  out  N_CHANNEL
//  m_axis_tready  in   N_CHANNEL              from each rifl_tx
//  lane_skew      out  $clog2(FIFO_DEPTH)+1   max minus min lane occupancy
//  skew_alarm     out  1                      sticky skew flag
//  beat_cnt       out  32                     accepted input beats, wraps at 2^32
// BEHAVIOUR
//  - Each lane FIFO entry stores {tlast, tkeep slice, tdata slice}. occ[i] ranges 0..FIFO_DEPTH.
//  - s_axis_tready = !rst && (occ[i] < FIFO_DEPTH for all i). This is combinational from the registered counts.
//  - A push happens when s_axis_tvalid && s_axis_tready. The beat is written to ALL lane FIFOs in the same cycle (all-or-none).
//  - A full lane blocks input even if it pops in the same cycle; there is no full-with-pop bypass.
//  - Lane i output: m_axis_tvalid[i] = (occ[i] != 0); data, keep and last come from the head entry.
//  - Lane i pops when m_axis_tvalid[i] && m_axis_tready[i].
//  - Latency: a beat pushed in cycle t is valid on every lane in cycle t+1.
//  - Push and pop on the same lane in the same cycle leave occ unchanged and keep ordering intact.
//  - The per-lane AXIS outputs are stable while valid and not ready.
//  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full vs empty is taken from occ, not from pointer equality.
//  - lane_skew is registered: it is max(occ) - min(occ) computed from the current-cycle occ registers. It updates one cycle after an occ change.
//  - If N_CHANNEL=1, lane_skew is always 0.
//  - skew_alarm sets in the cycle after lane_skew >= SKEW_LIMIT and stays set until rst.
//  - beat_cnt increments by 1 per accepted input beat and wraps 2^32-1 -> 0.
//  - Reset, synchronous, applies mid-transfer as well:
//    - all occ, pointers, lane_skew, skew_alarm and beat_cnt are 0; m_axis_tvalid = 0; s_axis_tready = 0 while rst is high;
//    - FIFO contents are discarded and not flushed;
//    - m_axis_tdata, tkeep and tlast are don't-care while tvalid = 0.
//  - Reset has priority over a simultaneous push or pop.
//  - The first push is possible in the first cycle with rst low.
//  - No state machine beyond the per-lane FIFO counters. Input is never backpressured by tvalid.
// TESTING
//  1 N=2, FW=32, all m_tready=1, push A0..A9 back-to-back -> each lane emits its slice in order.
//    Latency 1, tready stays 1, beat_cnt=10, lane_skew=0.
//  2 Lane1 tready=0, lane0=1, push 9 beats -> tready drops after 8 accepted, lane0 drains 8, lane1 holds 8.
//    lane_skew reaches 8, skew_alarm=1; lane1 release -> 8 beats in order, no duplicates.
//  3 Both lanes full, push offered and lane0 pops same cycle -> beat not accepted; accepted next cycle.
//  4 Lane0 occ=4, simultaneous push and pop on lane0 -> occ stays 4, output order preserved.
//  5 rst pulse for 1 cycle with occ=5/3 mid-stream -> next cycle occ=0, m_tvalid=0, skew_alarm=0, beat_cnt=0.
//    tready=1 the cycle after rst falls.
//  6 tlast=1 on beat 3, tkeep=0x0F on lane1 -> m_axis_tlast[0]=m_axis_tlast[1]=1 on beat 3 only.
//    Lane1 keep=0x0F on that beat.

Source files
------------

// File: rtl/rifl_tx_lane_dist.sv
// -----------------------------------------------------------------------------
// rifl_tx_lane_dist
// Splits one wide user AXI4-Stream beat (N_CHANNEL x FRAME_WIDTH) into
// N_CHANNEL independent per-lane frame streams. Every lane has its own FIFO,
// so lanes drain at their own pace. A beat is written to every lane in the
// same cycle or to none, so a stalled lane never causes a beat to be dropped
// or duplicated on another lane.
//
// Ports (all in the tx_frame_clk domain):
//   tx_frame_clk   : sole clock
//   rst            : synchronous, active-high reset
//   s_axis_*       : wide user input; lane i owns data slice
//                    [(i+1)*FRAME_WIDTH-1 -: FRAME_WIDTH] and the matching keep
//                    slice; tlast is copied to every lane
//   m_axis_*       : per-lane outputs taken from the head of each lane FIFO
//   lane_skew      : registered max(occ) - min(occ) across the lanes
//   skew_alarm     : sticky; set once lane_skew reaches SKEW_LIMIT
//   beat_cnt       : accepted input beats, wraps at 2^32
// -----------------------------------------------------------------------------
module rifl_tx_lane_dist #(
    parameter int N_CHANNEL   = 1,
    parameter int FRAME_WIDTH = 256,
    parameter int FIFO_DEPTH  = 8,
    parameter int SKEW_LIMIT  = 6
) (
    input  logic                              tx_frame_clk,
    input  logic                              rst,
    input  logic [N_CHANNEL*FRAME_WIDTH-1:0]  s_axis_tdata,
    input  logic [N_CHANNEL*FRAME_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [N_CHANNEL*FRAME_WIDTH-1:0]  m_axis_tdata,
    output logic [N_CHANNEL*FRAME_WIDTH/8-1:0] m_axis_tkeep,
    output logic [N_CHANNEL-1:0]              m_axis_tlast,
    output logic [N_CHANNEL-1:0]              m_axis_tvalid,
    input  logic [N_CHANNEL-1:0]              m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]       lane_skew,
    output logic                              skew_alarm,
    output logic [31:0]                       beat_cnt
);

    localparam int KW = FRAME_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int EW = 1 + KW + FRAME_WIDTH;

    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [OW-1:0] OCC_ONE = OW'(1'b1);
    localparam logic [OW-1:0] DEPTH_L = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] SKEW_L  = OW'(SKEW_LIMIT);

    logic                          push_s;
    logic [N_CHANNEL-1:0]          lane_full_s;
    logic [N_CHANNEL-1:0][OW-1:0]  occ_all_s;
    logic [OW-1:0]                 occ_max_s;
    logic [OW-1:0]                 occ_min_s;

    logic [OW-1:0]                 lane_skew_q, lane_skew_d;
    logic                          skew_alarm_q, skew_alarm_d;
    logic [31:0]                   beat_cnt_q, beat_cnt_d;

    // Input is accepted only when no lane is full; a lane popping in the same
    // cycle does not free a slot for the incoming beat.
    assign s_axis_tready = !rst && !(|lane_full_s);
    assign push_s        = s_axis_tvalid && s_axis_tready;

    for (genvar g = 0; g < N_CHANNEL; g++) begin : g_lane
        logic [EW-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [OW-1:0] occ_q, occ_d;
        logic          pop_s;
        logic [EW-1:0] entry_s;
        logic [EW-1:0] head_s;

        assign entry_s = {s_axis_tlast,
                          s_axis_tkeep[(g+1)*KW-1 -: KW],
                          s_axis_tdata[(g+1)*FRAME_WIDTH-1 -: FRAME_WIDTH]};
        assign head_s  = mem_q[rd_ptr_q];
        assign pop_s   = (occ_q != {OW{1'b0}}) && m_axis_tready[g];

        // Full/empty come from the occupancy count; pointers alone are ambiguous.
        assign lane_full_s[g] = (occ_q == DEPTH_L);
        assign occ_all_s[g]   = occ_q;

        assign m_axis_tvalid[g]                                   = (occ_q != {OW{1'b0}});
        assign m_axis_tdata[(g+1)*FRAME_WIDTH-1 -: FRAME_WIDTH]   = head_s[FRAME_WIDTH-1:0];
        assign m_axis_tkeep[(g+1)*KW-1 -: KW]                     = head_s[FRAME_WIDTH +: KW];
        assign m_axis_tlast[g]                                    = head_s[EW-1];

        // Next-state pointers and occupancy for this lane.
        always_comb begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end

        // Lane counters; contents are simply abandoned on reset.
        always_ff @(posedge tx_frame_clk) begin
            if (rst) begin
                wr_ptr_q <= {PW{1'b0}};
                rd_ptr_q <= {PW{1'b0}};
                occ_q    <= {OW{1'b0}};
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
            end
        end

        // Lane storage write port.
        always_ff @(posedge tx_frame_clk) begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= entry_s;
            end
        end
    end

    // Spread of lane occupancies; with a single lane max equals min.
    always_comb begin
        occ_max_s = occ_all_s[0];
        occ_min_s = occ_all_s[0];
        for (int i = 1; i < N_CHANNEL; i++) begin
            if (occ_all_s[i] > occ_max_s) begin
                occ_max_s = occ_all_s[i];
            end else begin
                occ_max_s = occ_max_s;
            end
            if (occ_all_s[i] < occ_min_s) begin
                occ_min_s = occ_all_s[i];
            end else begin
                occ_min_s = occ_min_s;
            end
        end
        lane_skew_d  = occ_max_s - occ_min_s;
        skew_alarm_d = skew_alarm_q || (lane_skew_q >= SKEW_L);
        if (push_s) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Status registers.
    always_ff @(posedge tx_frame_clk) begin
        if (rst) begin
            lane_skew_q  <= {OW{1'b0}};
            skew_alarm_q <= 1'b0;
            beat_cnt_q   <= 32'd0;
        end else begin
            lane_skew_q  <= lane_skew_d;
            skew_alarm_q <= skew_alarm_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign lane_skew  = lane_skew_q;
    assign skew_alarm = skew_alarm_q;
    assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_rifl_tx_lane_dist.sv
// -----------------------------------------------------------------------------
// tb_rifl_tx_lane_dist
// Two-lane, 32-bit-per-lane bench. Directed scenarios followed by a random
// phase. A negedge monitor keeps a per-lane queue of expected beats plus the
// expected status values, and compares every cycle.
// -----------------------------------------------------------------------------
module tb_rifl_tx_lane_dist;

    localparam int NC    = 2;
    localparam int FW    = 32;
    localparam int KW    = FW / 8;
    localparam int DEPTH = 8;
    localparam int SKL   = 6;
    localparam int EW    = 1 + KW + FW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*FW-1:0]  s_tdata;
    logic [NC*KW-1:0]  s_tkeep;
    logic              s_tlast;
    logic              s_tvalid;
    logic              s_axis_tready;
    logic [NC*FW-1:0]  m_axis_tdata;
    logic [NC*KW-1:0]  m_axis_tkeep;
    logic [NC-1:0]     m_axis_tlast;
    logic [NC-1:0]     m_axis_tvalid;
    logic [NC-1:0]     m_tready;
    logic [3:0]        lane_skew;
    logic              skew_alarm;
    logic [31:0]       beat_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [EW-1:0] exp_q [NC][$];
    logic [31:0]   exp_cnt   = 32'd0;
    int            exp_skew  = 0;
    bit            exp_alarm = 1'b0;

    always #5 clk = ~clk;

    rifl_tx_lane_dist #(
        .N_CHANNEL  (NC),
        .FRAME_WIDTH(FW),
        .FIFO_DEPTH (DEPTH),
        .SKEW_LIMIT (SKL)
    ) dut (
        .tx_frame_clk (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_tready),
        .lane_skew    (lane_skew),
        .skew_alarm   (skew_alarm),
        .beat_cnt     (beat_cnt)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare this cycle, then advance the model by
    // the handshakes that the coming clock edge will commit.
    always @(negedge clk) begin
        bit       exp_ready;
        int       sz0;
        int       sz1;
        logic [EW-1:0] head;
        exp_ready = !rst && (exp_q[0].size() < DEPTH) && (exp_q[1].size() < DEPTH);
        check("s_tready", {63'd0, s_axis_tready}, {63'd0, exp_ready});
        check("beat_cnt", {32'd0, beat_cnt}, {32'd0, exp_cnt});
        check("lane_skew", {60'd0, lane_skew}, 64'(exp_skew));
        check("skew_alarm", {63'd0, skew_alarm}, {63'd0, exp_alarm});
        for (int i = 0; i < NC; i++) begin
            check($sformatf("m_tvalid%0d", i), {63'd0, m_axis_tvalid[i]},
                  {63'd0, exp_q[i].size() != 0});
            if (exp_q[i].size() != 0) begin
                head = exp_q[i][0];
                check($sformatf("m_tdata%0d", i), {32'd0, m_axis_tdata[i*FW +: FW]},
                      {32'd0, head[FW-1:0]});
                check($sformatf("m_tkeep%0d", i), {60'd0, m_axis_tkeep[i*KW +: KW]},
                      {60'd0, head[FW +: KW]});
                check($sformatf("m_tlast%0d", i), {63'd0, m_axis_tlast[i]},
                      {63'd0, head[EW-1]});
            end
        end
        if (rst) begin
            for (int i = 0; i < NC; i++) exp_q[i].delete();
            exp_cnt   = 32'd0;
            exp_skew  = 0;
            exp_alarm = 1'b0;
        end else begin
            exp_alarm = exp_alarm || (exp_skew >= SKL);
            sz0 = exp_q[0].size();
            sz1 = exp_q[1].size();
            exp_skew = (sz0 > sz1) ? (sz0 - sz1) : (sz1 - sz0);
            for (int i = 0; i < NC; i++) begin
                if (exp_q[i].size() != 0 && m_tready[i]) void'(exp_q[i].pop_front());
            end
            if (s_tvalid && exp_ready) begin
                for (int i = 0; i < NC; i++)
                    exp_q[i].push_back({s_tlast, s_tkeep[i*KW +: KW], s_tdata[i*FW +: FW]});
                exp_cnt = exp_cnt + 32'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the currently offered beat is taken, then drop valid.
    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got tready=0 required tready=1", nm);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic offer(input logic [NC*KW-1:0] k, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = k;
        s_tlast  = l;
    endtask

    task automatic push_beat(input logic [NC*KW-1:0] k, input logic l);
        offer(k, l);
        wait_accept("push");
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_tready = 2'b11;
        @(negedge clk);
        while (m_axis_tvalid != 2'b00 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (m_axis_tvalid != 2'b00) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got m_tvalid=%b required 00", m_axis_tvalid);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        m_tready = 2'b11;
        repeat (3) tick();
        rst = 1'b0;

        // 1: back-to-back beats, all lanes ready
        for (int b = 0; b < 10; b++) push_beat(8'hFF, 1'b0);
        @(negedge clk);
        check("t1_beat_cnt", {32'd0, beat_cnt}, 64'd10);
        check("t1_skew", {60'd0, lane_skew}, 64'd0);
        drain();

        // 2: lane1 stalled, ninth beat blocked until lane1 released
        m_tready = 2'b01;
        for (int b = 0; b < 8; b++) push_beat(8'hFF, 1'b0);
        offer(8'hFF, 1'b0);
        repeat (4) @(negedge clk);
        check("t2_blocked", {63'd0, s_axis_tready}, 64'd0);
        check("t2_skew", {60'd0, lane_skew}, 64'd8);
        check("t2_alarm", {63'd0, skew_alarm}, 64'd1);
        @(posedge clk);
        #1;
        m_tready = 2'b11;
        wait_accept("t2_release");
        drain();

        // 3: both full, both pop while a beat is offered
        m_tready = 2'b00;
        for (int b = 0; b < 8; b++) push_beat(8'hFF, 1'b0);
        offer(8'hFF, 1'b1);
        m_tready = 2'b11;
        @(negedge clk);
        check("t3_full_block", {63'd0, s_axis_tready}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_accept_next", {63'd0, s_axis_tready}, 64'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        drain();

        // 4: lane0 at occ 4, then push and pop together
        m_tready = 2'b10;
        for (int b = 0; b < 4; b++) push_beat(8'hFF, 1'b0);
        m_tready = 2'b11;
        for (int b = 0; b < 6; b++) push_beat(8'($urandom), 1'($urandom));
        @(negedge clk);
        check("t4_skew", {60'd0, lane_skew}, 64'd3);
        drain();

        // 5: reset mid-stream with occ 5/3
        m_tready = 2'b00;
        for (int b = 0; b < 5; b++) push_beat(8'hFF, 1'b0);
        m_tready = 2'b10;
        tick();
        tick();
        m_tready = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid", {62'd0, m_axis_tvalid}, 64'd0);
        check("t5_cnt", {32'd0, beat_cnt}, 64'd0);
        check("t5_alarm", {63'd0, skew_alarm}, 64'd0);
        check("t5_ready", {63'd0, s_axis_tready}, 64'd1);
        tick();

        // 6: tlast on beat 3 with a partial keep on lane1
        m_tready = 2'b11;
        for (int b = 0; b < 6; b++) begin
            if (b == 3) push_beat({4'hF, 4'h5}, 1'b1);
            else        push_beat({4'h3, 4'hC}, 1'b0);
        end
        drain();

        // Random phase
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            m_tready = ((c / 150) % 2 == 0) ? 2'($urandom) : 2'($urandom & $urandom);
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = 8'($urandom);
            s_tlast  = 1'($urandom);
            tick();
        end
        rst      = 1'b0;
        s_tvalid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
